// File: rtl/spi_master_regmap_mc_pkg.sv
// Shared definitions for the SPI master register map: register addresses,
// revision ID, IRQ and CTL bit positions, and the decoded register select.
package spi_master_regmap_mc_pkg;

  // Register addresses (host word addresses)
  localparam logic [7:0] ADDR_SPIM_REVID       = 8'h00;
  localparam logic [7:0] ADDR_SPIM_SCRATCH     = 8'h01;
  localparam logic [7:0] ADDR_SPIM_CTL         = 8'h02;
  localparam logic [7:0] ADDR_SPIM_XFER_START  = 8'h03;
  localparam logic [7:0] ADDR_SPIM_XFER_STATUS = 8'h04;
  localparam logic [7:0] ADDR_SPIM_IRQ_STATUS  = 8'h05;
  localparam logic [7:0] ADDR_SPIM_IRQ_MASK    = 8'h06;
  localparam logic [7:0] ADDR_SPIM_CS_ENABLE   = 8'h07;
  localparam logic [7:0] ADDR_SPIM_CS_POLARITY = 8'h08;
  localparam logic [7:0] ADDR_SPIM_XFER_COUNT  = 8'h09;
  localparam logic [7:0] ADDR_SPIM_XFER_DELAY  = 8'h0A;
  localparam logic [7:0] ADDR_SPIM_WBUF_WRDATA = 8'h0B;
  localparam logic [7:0] ADDR_SPIM_RBUF_RDDATA = 8'h0C;
  localparam logic [7:0] ADDR_SPIM_TIMEOUT     = 8'h0D;

  localparam logic [15:0] DATA_SPIM_REVID = 16'h0201;

  // IRQ_STATUS / IRQ_MASK layout
  localparam int IRQ_WIDTH     = 12;
  localparam int IRQ_XFER_DONE = 0;
  localparam int IRQ_LOCK_ERR  = 1;
  localparam int IRQ_TIMEOUT   = 2;
  localparam int IRQ_RESERVED  = 3;
  localparam int IRQ_WB_LSB    = 4;
  localparam int IRQ_RB_LSB    = 8;

  // CTL layout {enable,3wire,burst,cpha,cpol,wb_mode,wr_lsb,rb_mode,rd_lsb}
  localparam int CTL_WIDTH   = 9;
  localparam int CTL_RD_LSB  = 0;
  localparam int CTL_RB_MODE = 1;
  localparam int CTL_WR_LSB  = 2;
  localparam int CTL_WB_MODE = 3;
  localparam int CTL_CPOL    = 4;
  localparam int CTL_CPHA    = 5;
  localparam int CTL_BURST   = 6;
  localparam int CTL_3WIRE   = 7;
  localparam int CTL_ENABLE  = 8;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_REVID,
    SEL_SCRATCH,
    SEL_CTL,
    SEL_XFER_START,
    SEL_XFER_STATUS,
    SEL_IRQ_STATUS,
    SEL_IRQ_MASK,
    SEL_CS_ENABLE,
    SEL_CS_POLARITY,
    SEL_XFER_COUNT,
    SEL_XFER_DELAY,
    SEL_WBUF,
    SEL_RBUF,
    SEL_TIMEOUT
  } reg_sel_e;

  // Registers that shape a transfer and therefore freeze while one is in flight.
  function automatic logic is_locked_reg(input reg_sel_e sel);
    return sel inside {SEL_CTL, SEL_CS_ENABLE, SEL_CS_POLARITY,
                       SEL_XFER_COUNT, SEL_XFER_DELAY};
  endfunction

endpackage

// File: rtl/spi_master_regmap_mc_if.sv
// Host register bus: separate write and read address phases, registered read data.
interface spi_master_regmap_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  sys_sel;
  logic                  sys_wr_en;
  logic                  sys_rd_en;
  logic [ADDR_WIDTH-1:0] sys_waddr;
  logic [DATA_WIDTH-1:0] sys_wdata;
  logic [ADDR_WIDTH-1:0] sys_raddr;
  logic [DATA_WIDTH-1:0] sys_rdata;

  modport master (
    output sys_sel, sys_wr_en, sys_rd_en, sys_waddr, sys_wdata, sys_raddr,
    input  sys_rdata
  );

  modport slave (
    input  sys_sel, sys_wr_en, sys_rd_en, sys_waddr, sys_wdata, sys_raddr,
    output sys_rdata
  );
endinterface

// File: rtl/spi_master_sync_edge.sv
// Multi-flop synchroniser for a slow level from another clock domain, with
// single-cycle rise/fall pulses derived from one extra flop behind the chain.
module spi_master_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              sync_d_q;

  // Shift the asynchronous level through the chain and keep a delayed copy.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      chain_q  <= '0;
      sync_d_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; blocking
      // here would collapse the chain into a single stage.
      chain_q  <= {chain_q[STAGES-2:0], async_in};
      sync_d_q <= chain_q[STAGES-1];
    end
  end

  assign sync_out = chain_q[STAGES-1];
  assign rise     = sync_out & ~sync_d_q;
  assign fall     = ~sync_out & sync_d_q;

endmodule

// File: rtl/spi_master_regmap_mc.sv
// Host-side register map for the multi-chip-select SPI master core.
// Optional watchdog on the transfer-busy flag: define SPIM_TIMEOUT_EN.
module spi_master_regmap_mc
  import spi_master_regmap_mc_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_CS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  spi_master_regmap_mc_if.slave host,
  output logic                  sys_wb_wr_en,
  output logic [DATA_WIDTH-1:0] sys_wb_wdata,
  output logic                  sys_rb_rd_en,
  input  logic [DATA_WIDTH-1:0] sys_rb_rdata,
  input  logic [3:0]            sys_wb_status,
  input  logic [3:0]            sys_rb_status,
  input  logic                  p_xfer_busy,
  output logic [CTL_WIDTH-1:0]  sys_ctl,
  output logic                  sys_xfer_start,
  output logic [DATA_WIDTH-1:0] sys_xfer_count,
  output logic [DATA_WIDTH-1:0] sys_xfer_delay,
  output logic [NUM_CS-1:0]     sys_cs_enable,
  output logic [NUM_CS-1:0]     sys_cs_polarity,
  output logic                  sys_irq
);

  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (addr)
      ADDR_WIDTH'(ADDR_SPIM_REVID):       sel = SEL_REVID;
      ADDR_WIDTH'(ADDR_SPIM_SCRATCH):     sel = SEL_SCRATCH;
      ADDR_WIDTH'(ADDR_SPIM_CTL):         sel = SEL_CTL;
      ADDR_WIDTH'(ADDR_SPIM_XFER_START):  sel = SEL_XFER_START;
      ADDR_WIDTH'(ADDR_SPIM_XFER_STATUS): sel = SEL_XFER_STATUS;
      ADDR_WIDTH'(ADDR_SPIM_IRQ_STATUS):  sel = SEL_IRQ_STATUS;
      ADDR_WIDTH'(ADDR_SPIM_IRQ_MASK):    sel = SEL_IRQ_MASK;
      ADDR_WIDTH'(ADDR_SPIM_CS_ENABLE):   sel = SEL_CS_ENABLE;
      ADDR_WIDTH'(ADDR_SPIM_CS_POLARITY): sel = SEL_CS_POLARITY;
      ADDR_WIDTH'(ADDR_SPIM_XFER_COUNT):  sel = SEL_XFER_COUNT;
      ADDR_WIDTH'(ADDR_SPIM_XFER_DELAY):  sel = SEL_XFER_DELAY;
      ADDR_WIDTH'(ADDR_SPIM_WBUF_WRDATA): sel = SEL_WBUF;
      ADDR_WIDTH'(ADDR_SPIM_RBUF_RDDATA): sel = SEL_RBUF;
`ifdef SPIM_TIMEOUT_EN
      ADDR_WIDTH'(ADDR_SPIM_TIMEOUT):     sel = SEL_TIMEOUT;
`endif
      default:                            sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  logic                  wr_stb, rd_stb;
  reg_sel_e              wsel, rsel;
  logic                  busy_sync, busy_fall;
  logic                  locked, lock_err, tmo_hit;
  logic                  xfer_start_d;
  logic [IRQ_WIDTH-1:0]  irq_status_q, irq_status_d, irq_mask_q;
  logic [DATA_WIDTH-1:0] scratch_q, rd_val;

  assign wr_stb   = host.sys_sel & host.sys_wr_en;
  assign rd_stb   = host.sys_sel & host.sys_rd_en;
  assign wsel     = decode(host.sys_waddr);
  assign rsel     = decode(host.sys_raddr);
  assign locked   = sys_xfer_start | busy_sync;
  assign lock_err = wr_stb & locked & is_locked_reg(wsel);

  spi_master_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_busy_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_in  (p_xfer_busy),
    .sync_out  (busy_sync),
    .rise      (),
    .fall      (busy_fall)
  );

`ifdef SPIM_TIMEOUT_EN
  logic [DATA_WIDTH-1:0] timeout_q, tmo_cnt_q;

  assign tmo_hit = busy_sync && (timeout_q != '0) && (tmo_cnt_q == timeout_q);

  // Watchdog: count busy cycles, hold at the limit until busy drops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timeout_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (wr_stb && wsel == SEL_TIMEOUT) timeout_q <= host.sys_wdata;
      if (!busy_sync)    tmo_cnt_q <= '0;
      else if (!tmo_hit) tmo_cnt_q <= tmo_cnt_q + DATA_WIDTH'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Transfer request: host sets/cancels, end of transfer or watchdog clears.
  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch forms.
    xfer_start_d = sys_xfer_start;
    if (wr_stb && wsel == SEL_XFER_START) begin
      if (host.sys_wdata[0])  xfer_start_d = 1'b1;
      else if (!busy_sync)    xfer_start_d = 1'b0;
    end
    if (busy_fall || tmo_hit) xfer_start_d = 1'b0;
  end

  // Sticky interrupt status: W1C first, then new events so a same-cycle set wins.
  always_comb begin
    irq_status_d = irq_status_q;
    if (wr_stb && wsel == SEL_IRQ_STATUS)
      irq_status_d = irq_status_d & ~host.sys_wdata[IRQ_WIDTH-1:0];
    irq_status_d[IRQ_XFER_DONE]       = irq_status_d[IRQ_XFER_DONE] | busy_fall;
    irq_status_d[IRQ_LOCK_ERR]        = irq_status_d[IRQ_LOCK_ERR]  | lock_err;
    irq_status_d[IRQ_TIMEOUT]         = irq_status_d[IRQ_TIMEOUT]   | tmo_hit;
    irq_status_d[IRQ_RESERVED]        = 1'b0;
    irq_status_d[IRQ_WB_LSB +: 4]     = irq_status_d[IRQ_WB_LSB +: 4] | sys_wb_status;
    irq_status_d[IRQ_RB_LSB +: 4]     = irq_status_d[IRQ_RB_LSB +: 4] | sys_rb_status;
  end

  // Control and configuration registers; transfer-shaping ones frozen while locked.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scratch_q       <= '0;
      irq_mask_q      <= '0;
      irq_status_q    <= '0;
      sys_irq         <= 1'b0;
      sys_xfer_start  <= 1'b0;
      sys_ctl         <= '0;
      sys_cs_enable   <= '0;
      sys_cs_polarity <= '0;
      sys_xfer_count  <= '0;
      sys_xfer_delay  <= DATA_WIDTH'(1);
    end else begin
      irq_status_q   <= irq_status_d;
      sys_irq        <= |(irq_status_q & irq_mask_q);
      sys_xfer_start <= xfer_start_d;
      if (wr_stb) begin
        case (wsel)
          SEL_SCRATCH:     scratch_q  <= host.sys_wdata;
          SEL_IRQ_MASK:    irq_mask_q <= host.sys_wdata[IRQ_WIDTH-1:0];
          SEL_CTL:         if (!locked) sys_ctl <= host.sys_wdata[CTL_WIDTH-1:0];
          SEL_CS_ENABLE:   if (!locked) sys_cs_enable <= host.sys_wdata[NUM_CS-1:0];
          SEL_CS_POLARITY: if (!locked) sys_cs_polarity <= host.sys_wdata[NUM_CS-1:0];
          SEL_XFER_COUNT:  if (!locked) sys_xfer_count <= host.sys_wdata;
          SEL_XFER_DELAY:  if (!locked)
                             sys_xfer_delay <= (host.sys_wdata == '0) ? DATA_WIDTH'(1)
                                                                      : host.sys_wdata;
          default: ;
        endcase
      end
    end
  end

  // Buffer push/pop pulses and the last pushed word.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sys_wb_wr_en <= 1'b0;
      sys_wb_wdata <= '0;
      sys_rb_rd_en <= 1'b0;
    end else begin
      sys_wb_wr_en <= wr_stb && wsel == SEL_WBUF;
      if (wr_stb && wsel == SEL_WBUF) sys_wb_wdata <= host.sys_wdata;
      sys_rb_rd_en <= rd_stb && rsel == SEL_RBUF;
    end
  end

  // Read-data multiplexer.
  always_comb begin
    rd_val = '0;
    case (rsel)
      SEL_REVID:       rd_val = DATA_WIDTH'(DATA_SPIM_REVID);
      SEL_SCRATCH:     rd_val = scratch_q;
      SEL_CTL:         rd_val = DATA_WIDTH'(sys_ctl);
      SEL_XFER_START:  rd_val = DATA_WIDTH'(sys_xfer_start);
      SEL_XFER_STATUS: rd_val = DATA_WIDTH'({sys_xfer_start, busy_sync});
      SEL_IRQ_STATUS:  rd_val = DATA_WIDTH'(irq_status_q);
      SEL_IRQ_MASK:    rd_val = DATA_WIDTH'(irq_mask_q);
      SEL_CS_ENABLE:   rd_val = DATA_WIDTH'(sys_cs_enable);
      SEL_CS_POLARITY: rd_val = DATA_WIDTH'(sys_cs_polarity);
      SEL_XFER_COUNT:  rd_val = sys_xfer_count;
      SEL_XFER_DELAY:  rd_val = sys_xfer_delay;
      SEL_WBUF:        rd_val = sys_wb_wdata;
      SEL_RBUF:        rd_val = sys_rb_rdata;
`ifdef SPIM_TIMEOUT_EN
      SEL_TIMEOUT:     rd_val = timeout_q;
`endif
      default:         rd_val = '0;
    endcase
  end

  // Registered read data; zero whenever no read is strobed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) host.sys_rdata <= '0;
    else            host.sys_rdata <= rd_stb ? rd_val : '0;
  end

endmodule

// File: tb/tb_spi_master_regmap_mc.sv
// Self-checking bench for spi_master_regmap_mc. Read expectations are queued
// when a read is issued and compared when the registered data appears.
// Honours SPIM_TIMEOUT_EN the same way as the design.
module tb_spi_master_regmap_mc;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NCS = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          sys_wb_wr_en, sys_rb_rd_en, sys_xfer_start, sys_irq;
  logic [DW-1:0] sys_wb_wdata, sys_rb_rdata, sys_xfer_count, sys_xfer_delay;
  logic [3:0]    sys_wb_status, sys_rb_status;
  logic          p_xfer_busy;
  logic [8:0]    sys_ctl;
  logic [NCS-1:0] sys_cs_enable, sys_cs_polarity;

  spi_master_regmap_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  spi_master_regmap_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CS(NCS), .SYNC_STAGES(2)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .host            (bus),
    .sys_wb_wr_en    (sys_wb_wr_en),
    .sys_wb_wdata    (sys_wb_wdata),
    .sys_rb_rd_en    (sys_rb_rd_en),
    .sys_rb_rdata    (sys_rb_rdata),
    .sys_wb_status   (sys_wb_status),
    .sys_rb_status   (sys_rb_status),
    .p_xfer_busy     (p_xfer_busy),
    .sys_ctl         (sys_ctl),
    .sys_xfer_start  (sys_xfer_start),
    .sys_xfer_count  (sys_xfer_count),
    .sys_xfer_delay  (sys_xfer_delay),
    .sys_cs_enable   (sys_cs_enable),
    .sys_cs_polarity (sys_cs_polarity),
    .sys_irq         (sys_irq)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;
  int wb_pulses = 0;
  int rb_pulses = 0;
  logic [DW-1:0] exp_q[$];
  string         tag_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge sys_clk);
    bus.sys_sel = 1'b1; bus.sys_wr_en = 1'b1; bus.sys_waddr = a; bus.sys_wdata = d;
    @(negedge sys_clk);
    bus.sys_sel = 1'b0; bus.sys_wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
    @(negedge sys_clk);
    bus.sys_sel = 1'b1; bus.sys_rd_en = 1'b1; bus.sys_raddr = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge sys_clk);
    bus.sys_sel = 1'b0; bus.sys_rd_en = 1'b0;
  endtask

  // Scoreboard: compare read data just after the capturing edge.
  always @(posedge sys_clk) begin
    if (bus.sys_sel && bus.sys_rd_en) begin
      #1;
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check(tag_q.pop_front(), bus.sys_rdata, exp_q.pop_front());
    end
  end

  // Pulse counters for the buffer strobes.
  always @(negedge sys_clk) begin
    if (sys_wb_wr_en) wb_pulses++;
    if (sys_rb_rd_en) rb_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    bus.sys_sel = 1'b0; bus.sys_wr_en = 1'b0; bus.sys_rd_en = 1'b0;
    bus.sys_waddr = '0; bus.sys_wdata = '0; bus.sys_raddr = '0;
    sys_rb_rdata = '0; sys_wb_status = '0; sys_rb_status = '0; p_xfer_busy = 1'b0;
    idle(3);
    sys_rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst_irq", sys_irq, 0);
    check("rst_delay", sys_xfer_delay, 1);
    check("rst_start", sys_xfer_start, 0);
    check("rst_ctl", sys_ctl, 0);
    bus_read(8'h00, 16'h0201, "rd_revid");
    bus_read(8'h0A, 16'h0001, "rd_delay_rst");
    bus_read(8'h05, 16'h0000, "rd_irq_rst");
    @(posedge sys_clk); #1;
    check("rdata_zero", bus.sys_rdata, 0);

    // Configuration registers while idle
    bus_write(8'h02, 16'hFFFF);
    check("ctl_out", sys_ctl, 9'h1FF);
    bus_read(8'h02, 16'h01FF, "rd_ctl");
    bus_write(8'h01, 16'hBEEF);
    bus_read(8'h01, 16'hBEEF, "rd_scratch");
    bus_write(8'h08, 16'h0035);
    check("cs_pol_out", sys_cs_polarity, 4'h5);
    bus_read(8'h08, 16'h0005, "rd_cs_pol");
    bus_write(8'h0A, 16'h0000);
    check("delay_zero_out", sys_xfer_delay, 1);
    bus_read(8'h0A, 16'h0001, "rd_delay_zero");
    bus_write(8'h0A, 16'h0007);
    bus_read(8'h0A, 16'h0007, "rd_delay_7");
    bus_write(8'h09, 16'h0003);
    check("count_out", sys_xfer_count, 3);
    bus_write(8'h20, 16'h5555);
    bus_read(8'h20, 16'h0000, "rd_unmapped");
    bus_write(8'h0D, 16'h0005);
`ifdef SPIM_TIMEOUT_EN
    bus_read(8'h0D, 16'h0005, "rd_timeout");
`else
    bus_read(8'h0D, 16'h0000, "rd_timeout_absent");
`endif
    bus_write(8'h0D, 16'h0000);

    // Transfer 1, IRQ masked: cancel, lock, completion
    bus_write(8'h03, 16'h0001);
    check("start_set", sys_xfer_start, 1);
    bus_read(8'h04, 16'h0002, "rd_status_req");
    bus_write(8'h03, 16'h0000);
    check("cancel_idle", sys_xfer_start, 0);
    bus_write(8'h03, 16'h0001);
    p_xfer_busy = 1'b1;
    idle(3);
    bus_read(8'h04, 16'h0003, "rd_status_busy");
    bus_write(8'h03, 16'h0000);
    check("cancel_ignored", sys_xfer_start, 1);
    bus_write(8'h07, 16'h000F);
    check("cs_locked", sys_cs_enable, 4'h0);
    bus_read(8'h05, 16'h0002, "rd_lock_err");
    bus_write(8'h05, 16'h0002);
    bus_read(8'h05, 16'h0000, "rd_lock_err_clr");
    p_xfer_busy = 1'b0;
    idle(2);
    check("start_hold", sys_xfer_start, 1);
    idle(1);
    check("start_clear", sys_xfer_start, 0);
    idle(1);
    check("irq_masked", sys_irq, 0);
    bus_read(8'h05, 16'h0001, "rd_xfer_done");
    bus_write(8'h06, 16'h0001);
    check("irq_lag", sys_irq, 0);
    idle(1);
    check("irq_rise", sys_irq, 1);
    bus_write(8'h05, 16'h0001);
    idle(1);
    check("irq_fall", sys_irq, 0);

    // Transfer 2, IRQ unmasked: sys_irq one cycle after the status bit
    bus_write(8'h03, 16'h0001);
    p_xfer_busy = 1'b1;
    idle(3);
    p_xfer_busy = 1'b0;
    idle(3);
    check("irq_not_yet", sys_irq, 0);
    idle(1);
    check("irq_after_done", sys_irq, 1);
    bus_write(8'h05, 16'h0001);
    bus_write(8'h07, 16'h000F);
    check("cs_unlocked", sys_cs_enable, 4'hF);

    // Sticky buffer status, set beats a same-cycle W1C
    @(negedge sys_clk); sys_rb_status = 4'b0100;
    @(negedge sys_clk); sys_rb_status = 4'b0000; sys_wb_status = 4'b1000;
    @(negedge sys_clk); sys_wb_status = 4'b0000;
    bus_read(8'h05, 16'h0480, "rd_sticky");
    @(negedge sys_clk);
    bus.sys_sel = 1'b1; bus.sys_wr_en = 1'b1; bus.sys_waddr = 8'h05; bus.sys_wdata = 16'h0480;
    sys_rb_status = 4'b0100;
    @(negedge sys_clk);
    bus.sys_sel = 1'b0; bus.sys_wr_en = 1'b0; sys_rb_status = 4'b0000;
    bus_read(8'h05, 16'h0400, "rd_set_wins");
    bus_write(8'h05, 16'h0400);
    bus_read(8'h05, 16'h0000, "rd_sticky_clr");
    check("irq_unmasked_bits", sys_irq, 0);

    // Buffer push and pop
    bus_write(8'h0B, 16'hA5A5);
    check("wb_data", sys_wb_wdata, 16'hA5A5);
    check("wb_pulse", sys_wb_wr_en, 1);
    bus_read(8'h0B, 16'hA5A5, "rd_wbuf_last");
    sys_rb_rdata = 16'h1234;
    bus_read(8'h0C, 16'h1234, "rd_rbuf");
    idle(2);
    check("wb_pulse_count", wb_pulses, 1);
    check("rb_pulse_count", rb_pulses, 1);

    // Watchdog
`ifdef SPIM_TIMEOUT_EN
    bus_write(8'h0D, 16'h0005);
`endif
    bus_write(8'h03, 16'h0001);
    p_xfer_busy = 1'b1;
    idle(6);
    check("tmo_pre", sys_xfer_start, 1);
    idle(2);
`ifdef SPIM_TIMEOUT_EN
    check("tmo_fire", sys_xfer_start, 0);
    bus_read(8'h05, 16'h0004, "rd_tmo");
`else
    check("no_tmo", sys_xfer_start, 1);
`endif
    p_xfer_busy = 1'b0;
    idle(4);
    check("tmo_end_start", sys_xfer_start, 0);
`ifdef SPIM_TIMEOUT_EN
    bus_read(8'h05, 16'h0005, "rd_tmo_done");
`else
    bus_read(8'h05, 16'h0001, "rd_done_no_tmo");
`endif
    bus_write(8'h05, 16'hFFFF);
    bus_write(8'h0D, 16'h0000);

    // Reset in the middle of a transfer
    bus_write(8'h03, 16'h0001);
    p_xfer_busy = 1'b1;
    idle(3);
    @(negedge sys_clk); sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_start", sys_xfer_start, 0);
    check("mid_rst_delay", sys_xfer_delay, 1);
    check("mid_rst_ctl", sys_ctl, 0);
    check("mid_rst_cs", sys_cs_enable, 0);
    sys_rst_n = 1'b1;
    p_xfer_busy = 1'b0;
    idle(3);
    bus_read(8'h01, 16'h0000, "rd_scratch_rst");
    bus_read(8'h04, 16'h0000, "rd_status_rst");

    idle(2);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
